// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle between the sequencer and the instruction/data memories.
interface multicycle_ctrl_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  // Sequencer side: issues requests, receives acks.
  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  // Memory side: receives requests, returns acks.
  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V core.
// Drives datapath strobes, runs imem/dmem req/ack with a wait timeout,
// counts retired instructions, and stops on SYSTEM, illegal opcode or timeout.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             opcode,
  input  logic                   zero,
  multicycle_ctrl_fsm_if.master  mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   alu_src,
  output logic [2:0]             alu_op,
  output logic [1:0]             imm_src,
  output logic                   retire,
  output logic [31:0]            instret,
  output logic                   halted,
  output logic                   err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // alu_op doubles as the instruction class for the rest of the instruction.
  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_I   = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_BR  = 3'b100;
  localparam logic [2:0] OP_JAL = 3'b101;
  localparam logic [2:0] OP_LUI = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  localparam logic [7:0] TO = TIMEOUT[7:0];

  logic [2:0] state, state_nxt;
  logic [7:0] wcnt;
  logic       live;       // low for the first cycle out of reset so no req shows during reset
  logic       dec_ok, dec_asrc;
  logic [2:0] dec_op;
  logic [1:0] dec_imm;
  logic       imem_req, dmem_req, dmem_we;

  // Opcode classification used when leaving DECODE.
  always_comb begin
    dec_ok   = 1'b1;
    dec_op   = OP_R;
    dec_imm  = 2'b00;
    dec_asrc = 1'b0;
    case (opcode)
      7'b0110011: dec_op = OP_R;
      7'b0010011: begin dec_op = OP_I;  dec_asrc = 1'b1; end
      7'b0000011: begin dec_op = OP_LD; dec_asrc = 1'b1; end
      7'b0100011: begin dec_op = OP_ST; dec_asrc = 1'b1; dec_imm = 2'b01; end
      7'b1100011: begin dec_op = OP_BR;  dec_imm = 2'b10; end
      7'b1101111: begin dec_op = OP_JAL; dec_imm = 2'b11; end
      7'b0110111: dec_op = OP_LUI;
      7'b1110011: dec_op = OP_SYS;
      default:    dec_ok = 1'b0;
    endcase
  end

  // Next-state: ack wins over timeout on the same cycle; timeout fires once wcnt hits TIMEOUT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (live && mem.imem_ack)  state_nxt = S_DECODE;
                else if (live && wcnt == TO) state_nxt = S_ERROR;
      S_DECODE: if (!dec_ok)               state_nxt = S_ERROR;
                else if (dec_op == OP_SYS) state_nxt = S_HALT;
                else                       state_nxt = S_EXEC;
      S_EXEC:   if (alu_op == OP_BR)                         state_nxt = S_FETCH;
                else if (alu_op == OP_LD || alu_op == OP_ST) state_nxt = S_MEM;
                else                                         state_nxt = S_WB;
      S_MEM:    if (mem.dmem_ack)          state_nxt = (alu_op == OP_LD) ? S_WB : S_FETCH;
                else if (wcnt == TO)       state_nxt = S_ERROR;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_ERROR;
    endcase
  end

  // State, wait counter and the liveness flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      wcnt  <= 8'd0;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (state_nxt != state)
        wcnt <= 8'd0;
      else if ((state == S_FETCH && live) || state == S_MEM)
        wcnt <= wcnt + 8'd1;
    end
  end

  // Decode results latched in DECODE and held for the rest of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= OP_R;
      imm_src    <= 2'b00;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
    end else if (state == S_DECODE) begin
      alu_op     <= dec_ok ? dec_op : OP_R;
      imm_src    <= dec_ok ? dec_imm : 2'b00;
      alu_src    <= dec_ok & dec_asrc;
      mem_to_reg <= dec_ok & (dec_op == OP_LD);
    end
  end

  // Datapath strobes: Moore from state, except ir_write and the MEM-state retire gated by ack.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = live;
        ir_write = live & mem.imem_ack;
      end
      S_EXEC: if (alu_op == OP_BR) begin
        pc_write = 1'b1;
        pc_src   = zero;
        retire   = 1'b1;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (alu_op == OP_ST);
        if (mem.dmem_ack && alu_op == OP_ST) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = (alu_op == OP_JAL);
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.imem_req = imem_req;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;
  assign halted       = (state == S_HALT);
  assign err          = (state == S_ERROR);

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with TIMEOUT=4.
module tb_multicycle_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src, retire, halted, err;
  logic [2:0]  alu_op;
  logic [1:0]  imm_src;
  logic [31:0] instret;
  int          passed = 0;
  int          total = 0;
  int          exp_ret = 0;

  multicycle_ctrl_fsm_if mif();

  multicycle_ctrl_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .imm_src(imm_src),
    .retire(retire), .instret(instret), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write, retire}
  logic [7:0] strb;
  assign strb = {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_write, pc_write, pc_src, reg_write, retire};

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Reset and release; returns in the first FETCH cycle with imem_req expected high.
  task automatic do_reset();
    rst_n = 1'b0; mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; #1;
    total++; if ({strb, alu_op, imm_src, mem_to_reg, alu_src, halted, err} !== 15'd0 || instret !== 32'd0)
      $display("FAIL reset_outputs strb=%b alu_op=%b imm=%b instret=%0d halted=%b err=%b", strb, alu_op, imm_src, instret, halted, err);
    else passed++;
    cyc(); rst_n = 1'b1; cyc();
    total++; if (strb !== 8'b1000_0000 || instret !== 32'd0)
      $display("FAIL reset_release strb=%b exp 10000000 instret=%0d exp 0", strb, instret);
    else passed++;
    exp_ret = 0;
  endtask

  // FETCH with ack after `waits` idle cycles, then DECODE; leaves the bench in the first post-DECODE cycle.
  task automatic fetch_decode(input logic [6:0] op, input int waits);
    opcode = op;
    for (int i = 0; i < waits; i++) begin
      #1; cyc();
    end
    mif.imem_ack = 1'b1; #1;
    total++; if (strb !== 8'b1001_0000) $display("FAIL fetch_ir_write strb=%b exp 10010000", strb); else passed++;
    cyc(); mif.imem_ack = 1'b0; #1;
    total++; if (strb !== 8'b0000_0000) $display("FAIL decode_quiet strb=%b exp 00000000", strb); else passed++;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_r_type();
    fetch_decode(7'b0110011, 0);
    total++; if ({alu_op, alu_src, mem_to_reg, strb} !== {3'b000, 1'b0, 1'b0, 8'b0})
      $display("FAIL r_exec alu_op=%b alu_src=%b strb=%b", alu_op, alu_src, strb); else passed++;
    cyc(); #1;
    total++; if (strb !== 8'b0000_1011) $display("FAIL r_wb strb=%b exp 00001011", strb); else passed++;
    cyc(); exp_ret++;
    total++; if (instret !== 32'(exp_ret) || strb !== 8'b1000_0000)
      $display("FAIL r_instret got %0d exp %0d strb=%b", instret, exp_ret, strb); else passed++;
  endtask

  task automatic test_load_wait();
    int reqs = 0;
    fetch_decode(7'b0000011, 0);
    total++; if ({alu_op, imm_src, alu_src, mem_to_reg} !== {3'b010, 2'b00, 1'b1, 1'b1})
      $display("FAIL ld_decode alu_op=%b imm=%b alu_src=%b m2r=%b", alu_op, imm_src, alu_src, mem_to_reg); else passed++;
    cyc();
    for (int i = 0; i < 4; i++) begin
      mif.dmem_ack = (i == 3); #1;
      if (strb === 8'b0100_0000) reqs++;
      cyc();
    end
    mif.dmem_ack = 1'b0;
    total++; if (reqs !== 4) $display("FAIL ld_req_cycles got %0d exp 4", reqs); else passed++;
    #1;
    total++; if (strb !== 8'b0000_1011 || mem_to_reg !== 1'b1)
      $display("FAIL ld_wb strb=%b exp 00001011 m2r=%b", strb, mem_to_reg); else passed++;
    cyc(); exp_ret++;
    total++; if (instret !== 32'(exp_ret) || strb !== 8'b1000_0000)
      $display("FAIL ld_done instret=%0d exp %0d strb=%b", instret, exp_ret, strb); else passed++;
  endtask

  task automatic test_store_branch();
    fetch_decode(7'b0100011, 0);
    total++; if ({alu_op, imm_src, alu_src, mem_to_reg} !== {3'b011, 2'b01, 1'b1, 1'b0})
      $display("FAIL st_decode alu_op=%b imm=%b", alu_op, imm_src); else passed++;
    cyc(); mif.dmem_ack = 1'b1; #1;
    total++; if (strb !== 8'b0110_1001) $display("FAIL st_mem strb=%b exp 01101001", strb); else passed++;
    cyc(); mif.dmem_ack = 1'b0; exp_ret++;
    total++; if (instret !== 32'(exp_ret) || strb !== 8'b1000_0000)
      $display("FAIL st_done instret=%0d exp %0d strb=%b", instret, exp_ret, strb); else passed++;
    for (int z = 1; z >= 0; z--) begin
      fetch_decode(7'b1100011, 0);
      zero = z[0]; #1;
      total++; if (strb !== {5'b0000_1, z[0], 2'b01} || alu_op !== 3'b100 || imm_src !== 2'b10)
        $display("FAIL br_exec zero=%0d strb=%b alu_op=%b imm=%b", z, strb, alu_op, imm_src); else passed++;
      cyc(); zero = 1'b0; exp_ret++;
      total++; if (instret !== 32'(exp_ret) || strb !== 8'b1000_0000)
        $display("FAIL br_done instret=%0d exp %0d strb=%b", instret, exp_ret, strb); else passed++;
    end
  endtask

  task automatic test_jal();
    fetch_decode(7'b1101111, 0);
    total++; if ({alu_op, imm_src, alu_src} !== {3'b101, 2'b11, 1'b0})
      $display("FAIL jal_decode alu_op=%b imm=%b", alu_op, imm_src); else passed++;
    cyc(); #1;
    total++; if (strb !== 8'b0000_1111) $display("FAIL jal_wb strb=%b exp 00001111", strb); else passed++;
    cyc(); exp_ret++;
  endtask

  // Ack on the 4th wait cycle (5th req cycle) is still accepted.
  task automatic test_ack_boundary();
    fetch_decode(7'b0010011, 4);
    total++; if ({alu_op, alu_src, imm_src, err} !== {3'b001, 1'b1, 2'b00, 1'b0})
      $display("FAIL i_boundary alu_op=%b alu_src=%b err=%b", alu_op, alu_src, err); else passed++;
    cyc(); cyc(); exp_ret++;
    total++; if (instret !== 32'(exp_ret)) $display("FAIL i_instret got %0d exp %0d", instret, exp_ret); else passed++;
  endtask

  task automatic test_timeout();
    int reqs = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (strb === 8'b1000_0000 && err === 1'b0) reqs++;
      cyc();
    end
    total++; if (reqs !== 5) $display("FAIL to_req_cycles got %0d exp 5", reqs); else passed++;
    mif.imem_ack = 1'b1; #1;
    total++; if (err !== 1'b1 || strb !== 8'b0) $display("FAIL to_err err=%b strb=%b", err, strb); else passed++;
    cyc(); cyc(); cyc();
    total++; if (err !== 1'b1 || strb !== 8'b0 || instret !== 32'(exp_ret))
      $display("FAIL to_hold err=%b strb=%b instret=%0d", err, strb, instret); else passed++;
    mif.imem_ack = 1'b0;
  endtask

  task automatic test_halt();
    int rets = 0;
    fetch_decode(7'b1110011, 0);
    for (int i = 0; i < 4; i++) begin
      #1; if (retire !== 1'b0 || halted !== 1'b1 || err !== 1'b0 || strb !== 8'b0) rets++;
      cyc();
    end
    total++; if (rets !== 0 || instret !== 32'(exp_ret))
      $display("FAIL halt bad_cycles=%0d instret=%0d exp %0d", rets, instret, exp_ret); else passed++;
  endtask

  task automatic test_illegal();
    fetch_decode(7'b1111111, 0);
    #1;
    total++; if (err !== 1'b1 || halted !== 1'b0 || strb !== 8'b0)
      $display("FAIL illegal err=%b halted=%b strb=%b", err, halted, strb); else passed++;
  endtask

  task automatic test_reset_mid_mem();
    fetch_decode(7'b0000011, 0);
    cyc(); #1;
    total++; if (strb !== 8'b0100_0000) $display("FAIL mid_mem_setup strb=%b exp 01000000", strb); else passed++;
    do_reset();
  endtask

  initial begin
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    #2;
    test_reset();
    test_r_type();
    test_load_wait();
    test_store_branch();
    test_jal();
    test_ack_boundary();
    test_timeout();
    do_reset();
    test_halt();
    do_reset();
    test_illegal();
    do_reset();
    test_r_type();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multi-cycle sequencer for the RISC-V core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-cycle enables of the shared datapath (PC, IR, register file, ALU, data memory). It runs a req/ack handshake with instruction and data memory, with a wait timeout on each. It also counts retired instructions and stops on ECALL/EBREAK, on an illegal opcode, or on a memory timeout.

## Interface
- TIMEOUT, 255: max cycles to wait for an ack (1..255); exceeding it is a fatal error.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in EXEC.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable; qualified by dmem_req.
- ir_write  out  1  IR load strobe.
- pc_write  out  1  PC update strobe.
- pc_src  out  1  0 = pc+4, 1 = branch/jump target.
- reg_write  out  1  register file write strobe.
- mem_to_reg  out  1  writeback source: 1 = load data.
- alu_src  out  1  1 = immediate operand.
- alu_op  out  3  ALU class: R=000, I=001, LD=010, ST=011, BR=100, JAL=101, LUI=110, SYS=111.
- imm_src  out  2  immediate format: I=00, S=01, B=10, J=11.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired instruction count.
- halted  out  1  sticky; set by ECALL/EBREAK.
- err  out  1  sticky; set by illegal opcode or timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR. Reset state is FETCH.
- FETCH:
  - imem_req=1 until imem_ack.
  - On ack: ir_write=1 in the same cycle, then go to DECODE.
- DECODE: one cycle. Classify opcode:
  - 0110011 R, 0010011 I, 0000011 LD, 0100011 ST, 1100011 BR, 1101111 JAL, 0110111 LUI, 1110011 SYS.
  - Register alu_op, imm_src, alu_src and mem_to_reg. These hold constant until the next DECODE.
  - alu_src=1 for I, LD and ST.
  - imm_src: I/LD=00, ST=01, BR=10, JAL=11, others 00.
  - SYS: go to HALT. Unknown opcode: go to ERROR. Otherwise go to EXEC.
- EXEC: one cycle.
  - BR: pc_write=1, pc_src=zero, retire; then FETCH.
  - LD, ST: go to MEM.
  - R, I, LUI, JAL: go to WB.
- MEM:
  - dmem_req=1 until dmem_ack; dmem_we=1 for ST.
  - On ack for LD: go to WB.
  - On ack for ST: pc_write=1, pc_src=0, retire; then FETCH.
- WB: one cycle.
  - reg_write=1.
  - pc_write=1, with pc_src=1 for JAL and 0 otherwise. The link value uses the pre-update PC because both writes land on the same edge.
  - retire; then FETCH.
- instret increments on every retire cycle and wraps 0xFFFFFFFF→0.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each cycle without ack. If the count reaches TIMEOUT with no ack, go to ERROR; no strobe is issued.
- HALT / ERROR:
  - Terminal until reset; all strobes and reqs are 0.
  - halted=1 in HALT, err=1 in ERROR.
  - instret holds its value.
- An ack received while the matching req is 0 is ignored.

## Timing
- Reset (async, immediate, rst_n=0):
  - All outputs 0.
  - alu_op=000, imm_src=00, instret=0, wait counter=0.
- First imem_req=1 occurs in the first cycle after rst_n deasserts.
- Control outputs are Moore-style from registered state, except:
  - ir_write, gated combinationally with imem_ack;
  - MEM-state pc_write/retire, gated with dmem_ack.
- Cycles per instruction with zero-wait ack (ack in the first req cycle):
  - BR: 3.
  - R, I, LUI, JAL, ST: 4.
  - LD: 5.
- Each wait cycle adds 1.
- Ack on exactly the TIMEOUT-th wait cycle is accepted; timeout fires the cycle after.
- Reset asserted mid-instruction aborts it. No partial strobe follows deassert.

## Test plan
- Reset with rst_n=0 mid-MEM:
  - all outputs drop to 0 within the same cycle;
  - after release, imem_req=1 next cycle and instret=0.
- R-type 0110011, zero-wait acks:
  - ir_write in cycle 1, alu_op=000 from cycle 2;
  - reg_write=pc_write=retire in cycle 4, pc_src=0;
  - instret=1.
- LD with dmem_ack delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we=0;
  - mem_to_reg=1 and reg_write in WB;
  - 8 cycles total.
- ST then BR with zero=1:
  - ST: dmem_we=1 and retire on ack, no reg_write;
  - BR: pc_write=1, pc_src=1 in EXEC, 3 cycles;
  - repeat BR with zero=0 → pc_src=0.
- No imem_ack, TIMEOUT=4:
  - err=1 after 5 req cycles;
  - no ir_write, imem_req=0 thereafter;
  - state holds until reset.
- Opcode 1110011:
  - halted=1 after DECODE, retire never pulses.
- Opcode 1111111:
  - err=1, no strobes.
